// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package cpu_pkg;

    localparam int REG_AW = 4;

    typedef enum logic [1:0] {
        RUN         = 2'd0,
        MEM_WAIT    = 2'd1,
        MEM_RELEASE = 2'd2
    } hc_state_e;

    localparam hc_state_e STATE_RESET = RUN;
    localparam logic      FLAG_CLR    = 1'b0;

endpackage

// File: rtl/raw_hazard_detect.sv
// Combinational RAW comparator between the ID sources and the EXE/MEM destinations.
// Build option FORWARDING_EN: only load-use against the EXE destination stalls.
module raw_hazard_detect #(
    parameter int REG_AW = cpu_pkg::REG_AW
) (
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              raw_hazard
);

`ifdef FORWARDING_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic exe_en;
    logic mem_en;
    logic src1_hit;
    logic src2_hit;

    // With forwarding, only a load still in EXE cannot be bypassed.
    assign exe_en = exe_wb_en && (!FWD || exe_mem_read);
    assign mem_en = mem_wb_en && !FWD;

    assign src1_hit = (exe_en && (id_src1 == exe_dest)) || (mem_en && (id_src1 == mem_dest));
    assign src2_hit = (exe_en && (id_src2 == exe_dest)) || (mem_en && (id_src2 == mem_dest));

    assign raw_hazard = (id_src1_used && src1_hit) || (id_two_src && src2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer: memory-wait FSM, pending branch, timeout flag and stall counter.
// FORWARDING_EN (in raw_hazard_detect) narrows the RAW check to load-use only.
module pipeline_hazard_controller #(
    parameter int REG_AW      = cpu_pkg::REG_AW,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_two_src,
    input  logic              id_src1_used,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic              exe_mem_read,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    input  logic              branch_taken,
    input  logic              mem_req,
    input  logic              sram_ready,
    output logic              hazard_freeze,
    output logic              if_id_flush,
    output logic              id_exe_flush,
    output logic              pipe_freeze,
    output logic              mem_timeout_err,
    output logic [CNT_W-1:0]  stall_count,
    output logic [1:0]        dbg_state
);
    import cpu_pkg::*;

    localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hc_state_e         state_q, state_d;
    logic              branch_pending_q, branch_pending_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              raw_hazard;
    logic              branch_flush;

    raw_hazard_detect #(.REG_AW(REG_AW)) u_raw (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_src1_used (id_src1_used),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .raw_hazard   (raw_hazard)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= STATE_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:         if (mem_req && !sram_ready) state_d = MEM_WAIT;
            MEM_WAIT:    if (sram_ready) state_d = MEM_RELEASE;
            MEM_RELEASE: state_d = RUN;
            default:     state_d = RUN;
        endcase
    end

    // The ready cycle itself does not freeze: the pipeline advances with the returned data.
    always_comb begin
        pipe_freeze   = 1'b0;
        hazard_freeze = 1'b0;
        if_id_flush   = 1'b0;
        id_exe_flush  = 1'b0;
        branch_flush  = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN:      pipe_freeze = mem_req && !sram_ready;
                MEM_WAIT: pipe_freeze = !sram_ready;
                default:  pipe_freeze = 1'b0;
            endcase
            if (!pipe_freeze) begin
                branch_flush  = branch_taken || ((state_q == MEM_RELEASE) && branch_pending_q);
                if_id_flush   = branch_flush;
                hazard_freeze = raw_hazard && !branch_flush;
                id_exe_flush  = branch_flush || hazard_freeze;
            end
        end
    end

    always_comb begin
        branch_pending_d = branch_pending_q;
        if (state_q == MEM_RELEASE) begin
            branch_pending_d = 1'b0;
        end else if (pipe_freeze && branch_taken) begin
            branch_pending_d = 1'b1;
        end

        wait_cnt_d = '0;
        if ((state_q == MEM_WAIT) && !sram_ready) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
        end

        timeout_err_d = timeout_err_q || ((state_q == MEM_WAIT) && (wait_cnt_q == WAIT_LAST));

        stall_cnt_d = stall_cnt_q;
        if ((pipe_freeze || hazard_freeze) && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_pending_q <= FLAG_CLR;
            wait_cnt_q       <= '0;
            timeout_err_q    <= FLAG_CLR;
            stall_cnt_q      <= '0;
        end else begin
            branch_pending_q <= branch_pending_d;
            wait_cnt_q       <= wait_cnt_d;
            timeout_err_q    <= timeout_err_d;
            stall_cnt_q      <= stall_cnt_d;
        end
    end

    assign mem_timeout_err = timeout_err_q;
    assign stall_count     = stall_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller; expectations follow FORWARDING_EN when defined.
module tb_pipeline_hazard_controller;
    import cpu_pkg::*;

    localparam int TB_AW      = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int TB_CNT_W   = 4;
    localparam int STALL_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [TB_AW-1:0]    id_src1, id_src2, exe_dest, mem_dest;
    logic                id_two_src, id_src1_used, exe_wb_en, exe_mem_read, mem_wb_en;
    logic                branch_taken, mem_req, sram_ready;
    logic                hazard_freeze, if_id_flush, id_exe_flush, pipe_freeze, mem_timeout_err;
    logic [TB_CNT_W-1:0] stall_count;
    logic [1:0]          dbg_state;
    logic [3:0]          got_flags;

    logic [3:0] exp_q[$];
    int         n_tests   = 0;
    int         n_fail    = 0;
    int         exp_stall = 0;
    logic       exp_err   = 1'b0;

    // Flag vector order: {pipe_freeze, hazard_freeze, if_id_flush, id_exe_flush}
    assign got_flags = {pipe_freeze, hazard_freeze, if_id_flush, id_exe_flush};

    always #5 clk = ~clk;

    pipeline_hazard_controller #(
        .REG_AW      (TB_AW),
        .MEM_TIMEOUT (TB_TIMEOUT),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_src1         (id_src1),
        .id_src2         (id_src2),
        .id_two_src      (id_two_src),
        .id_src1_used    (id_src1_used),
        .exe_dest        (exe_dest),
        .exe_wb_en       (exe_wb_en),
        .exe_mem_read    (exe_mem_read),
        .mem_dest        (mem_dest),
        .mem_wb_en       (mem_wb_en),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .sram_ready      (sram_ready),
        .hazard_freeze   (hazard_freeze),
        .if_id_flush     (if_id_flush),
        .id_exe_flush    (id_exe_flush),
        .pipe_freeze     (pipe_freeze),
        .mem_timeout_err (mem_timeout_err),
        .stall_count     (stall_count),
        .dbg_state       (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_src1      = '0;
        id_src2      = '0;
        exe_dest     = '0;
        mem_dest     = '0;
        id_two_src   = 1'b0;
        id_src1_used = 1'b0;
        exe_wb_en    = 1'b0;
        exe_mem_read = 1'b0;
        mem_wb_en    = 1'b0;
        branch_taken = 1'b0;
        mem_req      = 1'b0;
        sram_ready   = 1'b0;
    endtask

    // Called #1 after a rising edge with inputs already driven; returns #1 after the next edge.
    task automatic step(input string tag, input logic [3:0] flags, input logic [1:0] st);
        logic [3:0] exp_flags;
        exp_q.push_back(flags);
        @(negedge clk);
        exp_flags = exp_q.pop_front();
        check({tag, "_flags"}, 32'(got_flags), 32'(exp_flags));
        check({tag, "_state"}, 32'(dbg_state), 32'(st));
        check({tag, "_stall"}, 32'(stall_count), 32'(exp_stall));
        check({tag, "_err"}, 32'(mem_timeout_err), 32'(exp_err));
        if ((exp_flags[3] || exp_flags[2]) && exp_stall < STALL_MAX) exp_stall++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_raw;

        // Outputs must stay quiet while reset is held, whatever the inputs say.
        rst = 1'b1;
        idle();
        mem_req      = 1'b1;
        branch_taken = 1'b1;
        id_src1      = 4'd3;
        id_src1_used = 1'b1;
        exe_dest     = 4'd3;
        exe_wb_en    = 1'b1;
        exe_mem_read = 1'b1;
        #2;
        check("rst_flags", 32'(got_flags), 32'h0);
        check("rst_state", 32'(dbg_state), 32'(RUN));
        check("rst_stall", 32'(stall_count), 32'h0);
        check("rst_err", 32'(mem_timeout_err), 32'h0);
        @(posedge clk);
        #1;
        idle();
        rst = 1'b0;

        step("idle", 4'b0000, RUN);

        mem_req = 1'b1; sram_ready = 1'b1;
        step("zero_wait", 4'b0000, RUN);
        idle();
        step("zero_wait_after", 4'b0000, RUN);

        mem_req = 1'b1;
        step("mw_entry", 4'b1000, RUN);
        for (int i = 0; i < 3; i++) step("mw_wait", 4'b1000, MEM_WAIT);
        sram_ready = 1'b1;
        step("mw_ready", 4'b0000, MEM_WAIT);
        sram_ready = 1'b0;
        step("mw_release", 4'b0000, MEM_RELEASE);
        check("mw_stall4", 32'(stall_count), 32'd4);
        idle();
        step("mw_idle", 4'b0000, RUN);

        mem_req = 1'b1;
        step("br_entry", 4'b1000, RUN);
        step("br_wait1", 4'b1000, MEM_WAIT);
        branch_taken = 1'b1;
        step("br_wait2", 4'b1000, MEM_WAIT);
        branch_taken = 1'b0;
        step("br_wait3", 4'b1000, MEM_WAIT);
        sram_ready = 1'b1;
        step("br_ready", 4'b0000, MEM_WAIT);
        idle();
        step("br_release", 4'b0011, MEM_RELEASE);
        step("br_after", 4'b0000, RUN);

`ifdef FORWARDING_EN
        exp_raw = 4'b0000;
`else
        exp_raw = 4'b0101;
`endif
        idle();
        id_src1 = 4'd3; id_src1_used = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        step("raw_exe", exp_raw, RUN);
        exe_mem_read = 1'b1;
        step("raw_exe_load", 4'b0101, RUN);

        idle();
        id_src1 = 4'd3; id_src2 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        mem_dest = 4'd3; mem_wb_en = 1'b1;
        step("non_use", 4'b0000, RUN);

        idle();
        id_src2 = 4'd5; id_two_src = 1'b1; mem_dest = 4'd5; mem_wb_en = 1'b1;
        step("raw_mem_src2", exp_raw, RUN);

        idle();
        id_src2 = 4'd9; id_two_src = 1'b1; exe_dest = 4'd9; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        step("raw_exe_src2_load", 4'b0101, RUN);

        idle();
        branch_taken = 1'b1;
        step("branch_run", 4'b0011, RUN);
        id_src1 = 4'd3; id_src1_used = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        step("prio_branch_raw", 4'b0011, RUN);

        for (int i = 0; i < 6; i++) begin
            idle();
            id_src1 = 4'($urandom_range(0, 7));
            id_src2 = 4'($urandom_range(0, 7));
            id_src1_used = 1'b1; id_two_src = 1'b1;
            exe_dest = 4'($urandom_range(8, 15));
            mem_dest = 4'($urandom_range(8, 15));
            exe_wb_en = 1'b1; mem_wb_en = 1'b1; exe_mem_read = 1'b1;
            step("rand_nohit", 4'b0000, RUN);
        end
        for (int i = 0; i < 4; i++) begin
            idle();
            id_src1 = 4'($urandom_range(0, 15));
            id_src1_used = 1'b1;
            exe_dest = id_src1; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
            step("rand_hit", 4'b0101, RUN);
        end

        idle();
        mem_req = 1'b1;
        step("to_entry", 4'b1000, RUN);
        for (int c = 1; c <= 9; c++) begin
            if (c == 9) exp_err = 1'b1;
            step("to_wait", 4'b1000, MEM_WAIT);
        end
        sram_ready = 1'b1;
        step("to_ready", 4'b0000, MEM_WAIT);
        idle();
        step("to_release", 4'b0000, MEM_RELEASE);
        step("to_sticky", 4'b0000, RUN);
        check("stall_saturated", 32'(stall_count), 32'(STALL_MAX));

        mem_req = 1'b1;
        step("rw_entry", 4'b1000, RUN);
        branch_taken = 1'b1;
        step("rw_wait", 4'b1000, MEM_WAIT);
        branch_taken = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rw_rst_flags", 32'(got_flags), 32'h0);
        check("rw_rst_state", 32'(dbg_state), 32'(RUN));
        check("rw_rst_err", 32'(mem_timeout_err), 32'h0);
        check("rw_rst_stall", 32'(stall_count), 32'h0);
        exp_stall = 0;
        exp_err   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle();
        mem_req = 1'b1;
        step("rw_entry2", 4'b1000, RUN);
        sram_ready = 1'b1;
        step("rw_ready", 4'b0000, MEM_WAIT);
        idle();
        step("rw_release", 4'b0000, MEM_RELEASE);
        step("rw_idle", 4'b0000, RUN);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Drives freeze/flush into the IF/ID and ID/EX pipeline registers and a global freeze for all stage registers.
- Resolves three event types: RAW data hazards, taken-branch flushes and multi-cycle SRAM accesses.
- Sits beside the decode stage and consumes stage-register destination fields plus SRAM controller handshake.

Parameters:
- REG_AW, 4, register index width.
- MEM_TIMEOUT, 64, SRAM wait cycles before the error flag is raised.
- CNT_W, 16, stall-statistics counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_src1  in  REG_AW  Rn index of the instruction in ID
- id_src2  in  REG_AW  Rm/Rd-store index of the instruction in ID
- id_two_src  in  1  ID instruction reads src2
- id_src1_used  in  1  ID instruction reads src1 (0 for MOV/MVN/B)
- exe_dest  in  REG_AW  ID/EX destination
- exe_wb_en  in  1  ID/EX write-back enable
- exe_mem_read  in  1  ID/EX is a load
- mem_dest  in  REG_AW  EX/MEM destination
- mem_wb_en  in  1  EX/MEM write-back enable
- branch_taken  in  1  taken branch resolved in EXE
- mem_req  in  1  MEM stage issues an SRAM read/write
- sram_ready  in  1  SRAM controller access complete
- hazard_freeze  out  1  hold PC and IF/ID
- if_id_flush  out  1  clear IF/ID
- id_exe_flush  out  1  bubble into ID/EX
- pipe_freeze  out  1  hold every stage register (memory wait)
- mem_timeout_err  out  1  sticky timeout flag
- stall_count  out  CNT_W  saturating count of freeze cycles

Behaviour:
- Reset values (async):
  - state=RUN, branch_pending=0, wait_cnt=0, stall_count=0, mem_timeout_err=0.
  - All freeze/flush outputs are 0 while rst is high.
- FSM states: RUN, MEM_WAIT, MEM_RELEASE.
  - RUN: on mem_req && !sram_ready, go to MEM_WAIT. mem_req && sram_ready in the same cycle is a zero-wait access; stay in RUN with no freeze.
  - MEM_WAIT: pipe_freeze=1 combinationally. On sram_ready, go to MEM_RELEASE.
  - MEM_RELEASE: pipe_freeze=0 for exactly one cycle, which blocks re-entry for the same mem_req. Always returns to RUN.
- Entry-cycle freeze: in RUN, pipe_freeze = mem_req && !sram_ready, so the first wait cycle also freezes.
- Hazard detection is combinational (same cycle). The RAW condition is:
  - (id_src1_used && src1 matches) || (id_two_src && src2 matches)
  - A match is against exe_dest with exe_wb_en, or against mem_dest with mem_wb_en, subject to the optional feature.
- Outputs when a hazard is detected:
  - hazard_freeze=1 and id_exe_flush=1 (bubble).
  - if_id_flush=0.
- Branch: branch_taken drives if_id_flush=1 and id_exe_flush=1 for that cycle and suppresses hazard_freeze. The wrong-path instruction stall is irrelevant.
- Priority, highest first: pipe_freeze > branch flush > hazard stall.
  - While pipe_freeze=1, all other outputs are 0.
  - A branch_taken seen during MEM_WAIT sets branch_pending.
  - Pending flushes are issued in MEM_RELEASE, then branch_pending is cleared.
- Timeout:
  - wait_cnt increments each MEM_WAIT cycle and clears on leaving MEM_WAIT.
  - When wait_cnt == MEM_TIMEOUT-1, set mem_timeout_err. It stays set until reset.
  - The FSM keeps waiting; there is no forced exit.
- stall_count increments on any cycle with pipe_freeze or hazard_freeze. It saturates at all-ones with no wrap.
- Reset mid-MEM_WAIT: returns to RUN immediately and drops pending branch.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined:
  - Only load-use hazards stall: exe_mem_read && exe_wb_en && src matches exe_dest.
  - mem_dest compare is ignored because the forwarding unit covers it.
- Undefined: full RAW check against both EXE and MEM destinations, as described above.

Decomposition:
- Shared package (cpu_pkg):
  - REG_AW.
  - FSM state enum {RUN, MEM_WAIT, MEM_RELEASE}.
  - Reset/zero constants.
- Sub-module raw_hazard_detect: purely combinational source/dest comparator, with FORWARDING_EN inside it.
- The FSM, pending branch, timeout and counters stay in the top.

Test Plan:
- RAW on EXE: id_src1=3, id_src1_used=1, exe_dest=3, exe_wb_en=1 -> hazard_freeze=1, id_exe_flush=1. The result is the same with exe_mem_read=1 under FORWARDING_EN, but 0 with exe_mem_read=0 under FORWARDING_EN.
- Non-use: id_src1_used=0, id_two_src=0, same dests -> no stall. mem_dest=5 matched by src2 with id_two_src=1 -> stall only without FORWARDING_EN.
- Memory wait: mem_req=1, sram_ready low for 4 cycles -> pipe_freeze=1 for those 4 cycles, 0 in the ready cycle, state=MEM_RELEASE for one cycle, stall_count=4.
- Branch during wait: branch_taken pulsed in cycle 2 of MEM_WAIT -> no flush during wait; if_id_flush=id_exe_flush=1 in the MEM_RELEASE cycle only.
- Timeout: MEM_TIMEOUT=8, sram_ready held low 10 cycles -> mem_timeout_err rises after the 8th wait cycle and stays 1 after ready. Assert rst -> clears to 0 asynchronously with state=RUN.
- Priority: branch_taken and RAW match in the same RUN cycle -> if_id_flush=1, id_exe_flush=1, hazard_freeze=0.
